// File: rtl/rf_mp_sb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rf_mp_sb_pkg
//  Description : Shared types and helpers for the multi-port register file
//                with scoreboard and bulk-clear engine.
//  Revision    : 1.0 - initial release
// ============================================================================
package rf_mp_sb_pkg;

    // Clear engine states; one bit is enough for the two-state machine
    typedef enum logic [0:0] {
        RF_IDLE  = 1'b0,
        RF_CLEAR = 1'b1
    } rf_clr_state_e;

    // Address width for a given number of entries
    function automatic int unsigned rf_aw(input int unsigned depth);
        return $clog2(depth);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rf_mp_sb_clr_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : rf_mp_sb_clr_fsm
//  Description : Sequential bulk-clear engine. Walks every entry once, one per
//                cycle, and hands a clear strobe plus index to the array.
//  Revision    : 1.0 - initial release
// ============================================================================
module rf_mp_sb_clr_fsm
    import rf_mp_sb_pkg::*;
#(
    parameter int unsigned DEPTH = 32,
    parameter int unsigned AW    = 5
)
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_req,
    output logic          clr_busy,
    output logic          clr_stb,
    output logic [AW-1:0] clr_idx
);

    // Counter is one bit wider than the index so it never wraps on the last entry
    localparam logic [AW:0] C_LAST = (AW+1)'(DEPTH - 1);

    rf_clr_state_e r_state;
    rf_clr_state_e w_state_nxt;
    logic [AW:0]   r_cnt;
    logic [AW:0]   w_cnt_nxt;

    // State and counter register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= RF_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state logic: start on request, exit after the last entry is cleared
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            RF_IDLE: begin
                if (clr_req) begin
                    w_state_nxt = RF_CLEAR;
                    w_cnt_nxt   = '0;
                end
            end
            RF_CLEAR: begin
                w_cnt_nxt = r_cnt + 1'b1;
                if (r_cnt == C_LAST) begin
                    w_state_nxt = RF_IDLE;
                end
            end
            default: begin
                w_state_nxt = RF_IDLE;
            end
        endcase
    end

    // Busy and strobe come straight from the state flop
    assign clr_busy = (r_state == RF_CLEAR);
    assign clr_stb  = (r_state == RF_CLEAR);
    assign clr_idx  = r_cnt[AW-1:0];

endmodule
`default_nettype wire

// File: rtl/rf_mp_sb.sv
`default_nettype none
// ============================================================================
//  Module      : rf_mp_sb
//  Description : Multi-port register file, NR read / 2 write ports, with
//                same-cycle write-to-read bypass, per-entry pending scoreboard
//                and a sequential bulk-clear engine.
//  Revision    : 1.0 - initial release
// ============================================================================
module rf_mp_sb
    import rf_mp_sb_pkg::*;
#(
    parameter  int unsigned W       = 32,
    parameter  int unsigned DEPTH   = 32,
    parameter  int unsigned NR      = 2,
    parameter  int unsigned ZERO_R0 = 1,
    parameter  int unsigned BYPASS  = 1,
    localparam int unsigned AW      = rf_aw(DEPTH)
)
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic [1:0]      we,
    input  logic [2*AW-1:0] waddr,
    input  logic [2*W-1:0]  wdata,
    input  logic [NR*AW-1:0] raddr,
    output logic [NR*W-1:0] rdata,
    output logic [NR-1:0]   rpend,
    input  logic            iss_vld,
    input  logic [AW-1:0]   iss_addr,
    input  logic            clr_req,
    output logic            clr_busy
);

    localparam bit C_ZERO_R0 = (ZERO_R0 != 0);
    localparam bit C_BYPASS  = (BYPASS != 0);

    logic [W-1:0]     r_mem [DEPTH];
    logic [DEPTH-1:0] r_pend;

    logic [1:0]       w_we;
    logic [AW-1:0]    w_wa [2];
    logic [W-1:0]     w_wd [2];
    logic             w_iss;
    logic             w_clr_busy;
    logic             w_clr_stb;
    logic [AW-1:0]    w_clr_idx;

    rf_mp_sb_clr_fsm #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_clr_fsm (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_req  (clr_req),
        .clr_busy (w_clr_busy),
        .clr_stb  (w_clr_stb),
        .clr_idx  (w_clr_idx)
    );

    assign clr_busy = w_clr_busy;

    // Effective write enables: dropped while clearing and when aimed at a hardwired entry 0
    for (genvar k = 0; k < 2; k++) begin : g_wport
        assign w_wa[k] = waddr[k*AW +: AW];
        assign w_wd[k] = wdata[k*W +: W];
        assign w_we[k] = we[k] & ~w_clr_busy & ~(C_ZERO_R0 && (w_wa[k] == '0));
    end

    // Issue is dropped while clearing; entry 0 is never marked when hardwired
    assign w_iss = iss_vld & ~w_clr_busy & ~(C_ZERO_R0 && (iss_addr == '0));

    // Array and scoreboard update: clear first, then port 1 over port 0, issue over write
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_pend <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_clr_stb && (w_clr_idx == AW'(i))) begin
                    r_mem[i]  <= '0;
                    r_pend[i] <= 1'b0;
                end else begin
                    if (w_we[1] && (w_wa[1] == AW'(i))) begin
                        r_mem[i] <= w_wd[1];
                    end else if (w_we[0] && (w_wa[0] == AW'(i))) begin
                        r_mem[i] <= w_wd[0];
                    end
                    if (w_iss && (iss_addr == AW'(i))) begin
                        r_pend[i] <= 1'b1;
                    end else if ((w_we[0] && (w_wa[0] == AW'(i))) ||
                                 (w_we[1] && (w_wa[1] == AW'(i)))) begin
                        r_pend[i] <= 1'b0;
                    end
                end
            end
        end
    end

    // Read ports: zero entry, then bypass of the winning write, then stored value
    for (genvar j = 0; j < NR; j++) begin : g_rport
        logic [AW-1:0] w_ra;
        logic          w_hit0;
        logic          w_hit1;
        logic          w_zero;
        logic          w_iss_hit;

        assign w_ra      = raddr[j*AW +: AW];
        assign w_hit0    = w_we[0] && (w_wa[0] == w_ra);
        assign w_hit1    = w_we[1] && (w_wa[1] == w_ra);
        assign w_zero    = C_ZERO_R0 && (w_ra == '0);
        assign w_iss_hit = w_iss && (iss_addr == w_ra);

        assign rdata[j*W +: W] = w_zero                ? '0      :
                                 (C_BYPASS && w_hit1)  ? w_wd[1] :
                                 (C_BYPASS && w_hit0)  ? w_wd[0] :
                                                         r_mem[w_ra];

        // A same-cycle write resolves the hazard unless a new producer issues too
        assign rpend[j] = w_zero ? 1'b0 :
                          (C_BYPASS && (w_hit0 || w_hit1) && !w_iss_hit) ? 1'b0 :
                          r_pend[w_ra];
    end

endmodule
`default_nettype wire

// File: tb/tb_rf_mp_sb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rf_mp_sb
//  Description : Self-checking bench for rf_mp_sb. Runs a bypassing and a
//                non-bypassing instance side by side against a behavioural
//                model of the register file, scoreboard and clear engine.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rf_mp_sb;

    localparam int W     = 32;
    localparam int DEPTH = 32;
    localparam int AW    = 5;
    localparam int NR    = 2;

    logic              clk;
    logic              rst_n;
    logic [1:0]        we;
    logic [2*AW-1:0]   waddr;
    logic [2*W-1:0]    wdata;
    logic [NR*AW-1:0]  raddr;
    logic              iss_vld;
    logic [AW-1:0]     iss_addr;
    logic              clr_req;

    logic [NR*W-1:0]   rdata;
    logic [NR-1:0]     rpend;
    logic              clr_busy;
    logic [NR*W-1:0]   rdata_nb;
    logic [NR-1:0]     rpend_nb;
    logic              clr_busy_nb;

    int checks   = 0;
    int failures = 0;

    // Reference state
    logic [W-1:0] mem_m  [DEPTH];
    bit           pend_m [DEPTH];
    bit           busy_m;
    int           cnt_m;

    rf_mp_sb u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (we),
        .waddr    (waddr),
        .wdata    (wdata),
        .raddr    (raddr),
        .rdata    (rdata),
        .rpend    (rpend),
        .iss_vld  (iss_vld),
        .iss_addr (iss_addr),
        .clr_req  (clr_req),
        .clr_busy (clr_busy)
    );

    rf_mp_sb #(.BYPASS(0)) u_dut_nb (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (we),
        .waddr    (waddr),
        .wdata    (wdata),
        .raddr    (raddr),
        .rdata    (rdata_nb),
        .rpend    (rpend_nb),
        .iss_vld  (iss_vld),
        .iss_addr (iss_addr),
        .clr_req  (clr_req),
        .clr_busy (clr_busy_nb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] exp_rdata(input int a, input bit byp);
        if (a == 0) return '0;
        if (byp && !busy_m) begin
            if (we[1] && waddr[2*AW-1:AW] == a) return wdata[2*W-1:W];
            if (we[0] && waddr[AW-1:0] == a)    return wdata[W-1:0];
        end
        return mem_m[a];
    endfunction

    function automatic bit exp_rpend(input int a, input bit byp);
        bit hit;
        if (a == 0) return 1'b0;
        hit = (we[1] && waddr[2*AW-1:AW] == a) || (we[0] && waddr[AW-1:0] == a);
        if (byp && !busy_m && hit && !(iss_vld && iss_addr == a)) return 1'b0;
        return pend_m[a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            mem_m[i]  = '0;
            pend_m[i] = 1'b0;
        end
        busy_m = 1'b0;
        cnt_m  = 0;
    endtask

    task automatic model_update();
        int a;
        if (!rst_n) begin
            model_reset();
        end else if (busy_m) begin
            mem_m[cnt_m]  = '0;
            pend_m[cnt_m] = 1'b0;
            if (cnt_m == DEPTH - 1) busy_m = 1'b0;
            else cnt_m++;
        end else begin
            for (int k = 0; k < 2; k++) begin
                a = int'(waddr[k*AW +: AW]);
                if (we[k] && a != 0) begin
                    mem_m[a]  = wdata[k*W +: W];
                    pend_m[a] = 1'b0;
                end
            end
            if (iss_vld && iss_addr != 0) pend_m[iss_addr] = 1'b1;
            if (clr_req) begin
                busy_m = 1'b1;
                cnt_m  = 0;
            end
        end
    endtask

    task automatic check_all();
        int a;
        for (int j = 0; j < NR; j++) begin
            a = int'(raddr[j*AW +: AW]);
            chk($sformatf("rdata%0d", j),    rdata[j*W +: W],    exp_rdata(a, 1'b1));
            chk($sformatf("rpend%0d", j),    rpend[j],           exp_rpend(a, 1'b1));
            chk($sformatf("nb_rdata%0d", j), rdata_nb[j*W +: W], exp_rdata(a, 1'b0));
            chk($sformatf("nb_rpend%0d", j), rpend_nb[j],        exp_rpend(a, 1'b0));
        end
        chk("clr_busy",    clr_busy,    busy_m);
        chk("nb_clr_busy", clr_busy_nb, busy_m);
    endtask

    // Inputs are set at negedge; outputs checked 1ns later; model steps at posedge
    task automatic cycle();
        #1;
        check_all();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        we = 2'b00; iss_vld = 1'b0; clr_req = 1'b0;
    endtask

    task automatic fill_index();
        idle_inputs();
        for (int a = 1; a < DEPTH; a++) begin
            we = 2'b01; waddr = {5'd0, 5'(a)}; wdata = {32'd0, 32'(a)};
            raddr = {5'(a), 5'(a - 1)};
            cycle();
        end
        idle_inputs();
    endtask

    task automatic read_all();
        idle_inputs();
        for (int a = 0; a < DEPTH; a += 2) begin
            raddr = {5'(a + 1), 5'(a)};
            cycle();
        end
    endtask

    initial begin
        int n;
        rst_n = 1'b0; we = '0; waddr = '0; wdata = '0; raddr = '0;
        iss_vld = 1'b0; iss_addr = '0; clr_req = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);

        // Reset state seen at address 5
        raddr = {5'd5, 5'd5};
        #1;
        chk("rst_rdata", rdata, 64'd0);
        chk("rst_rpend", {62'd0, rpend}, 64'd0);
        chk("rst_busy", clr_busy, 1'b0);
        cycle();
        rst_n = 1'b1;
        cycle();

        // Dual write to the same address: port 1 wins, bypass vs stored
        we = 2'b11; waddr = {5'd3, 5'd3}; wdata = {32'h22, 32'h11}; raddr = {5'd0, 5'd3};
        #1;
        chk("t2_bypass", rdata[W-1:0], 32'h22);
        chk("t2_nobypass", rdata_nb[W-1:0], 32'h0);
        cycle();
        idle_inputs();
        #1;
        chk("t2_stored", rdata[W-1:0], 32'h22);
        chk("t2_nb_stored", rdata_nb[W-1:0], 32'h22);
        cycle();

        // Writes to entry 0 are ignored
        we = 2'b01; waddr = {5'd0, 5'd0}; wdata = {32'd0, 32'hDEAD}; raddr = {5'd0, 5'd0};
        iss_vld = 1'b1; iss_addr = 5'd0;
        cycle();
        idle_inputs();
        #1;
        chk("t3_r0_data", rdata[W-1:0], 32'h0);
        chk("t3_r0_pend", rpend[0], 1'b0);
        cycle();

        // Scoreboard: issue, bypass clear, issue-over-write
        iss_vld = 1'b1; iss_addr = 5'd7; raddr = {5'd3, 5'd7};
        cycle();
        idle_inputs();
        #1;
        chk("t4_pend_set", rpend[0], 1'b1);
        cycle();
        we = 2'b01; waddr = {5'd0, 5'd7}; wdata = {32'd0, 32'h77};
        #1;
        chk("t4_pend_byp", rpend[0], 1'b0);
        chk("t4_nb_pend", rpend_nb[0], 1'b1);
        cycle();
        idle_inputs();
        #1;
        chk("t4_pend_after", rpend[0], 1'b0);
        cycle();
        iss_vld = 1'b1; iss_addr = 5'd7; we = 2'b10; waddr = {5'd7, 5'd0}; wdata = {32'h99, 32'd0};
        #1;
        chk("t4_iss_wr_same", rpend[0], 1'b0);
        cycle();
        idle_inputs();
        #1;
        chk("t4_set_wins", rpend[0], 1'b1);
        cycle();

        // Bulk clear with writes and issues attempted during the clear
        fill_index();
        clr_req = 1'b1;
        cycle();
        clr_req = 1'b0;
        n = 0;
        while (clr_busy && n < 40) begin
            n++;
            we = 2'($urandom_range(0, 3)); waddr = 10'($urandom);
            wdata = {$urandom, $urandom};
            iss_vld = 1'($urandom); iss_addr = 5'($urandom);
            clr_req = 1'($urandom);
            raddr = {5'(n), 5'(n - 1)};
            cycle();
        end
        idle_inputs();
        chk("t5_busy_len", n, 32);
        raddr = {5'd0, 5'd9};
        #1;
        chk("t5_cleared", rdata[W-1:0], 32'h0);
        read_all();

        // Reset in the middle of a clear, then restart from entry 0
        fill_index();
        clr_req = 1'b1;
        cycle();
        clr_req = 1'b0;
        for (int i = 0; i < 10; i++) begin
            raddr = {5'(i + 12), 5'(i + 1)};
            cycle();
        end
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        #1;
        chk("t6_busy_abort", clr_busy, 1'b0);
        read_all();
        we = 2'b01; waddr = {5'd0, 5'd1}; wdata = {32'd0, 32'h5A5A};
        cycle();
        idle_inputs();
        clr_req = 1'b1;
        raddr = {5'd1, 5'd1};
        cycle();
        clr_req = 1'b0;
        #1;
        chk("t6_restart_e1", rdata[W-1:0], 32'h5A5A);
        n = 0;
        while (clr_busy && n < 40) begin
            n++;
            cycle();
        end
        chk("t6_busy_len", n, 32);

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            we       = 2'($urandom_range(0, 3));
            waddr    = 10'($urandom);
            wdata    = {$urandom, $urandom};
            raddr    = 10'($urandom);
            iss_vld  = 1'($urandom);
            iss_addr = 5'($urandom);
            if (($urandom & 32'h3) == 0) begin
                iss_addr = waddr[AW-1:0];
                raddr[AW-1:0] = waddr[AW-1:0];
            end
            if (($urandom & 32'h3) == 0) raddr[2*AW-1:AW] = waddr[2*AW-1:AW];
            clr_req  = (($urandom & 32'h7F) == 0);
            rst_n    = (($urandom & 32'h1FF) != 0);
            cycle();
        end
        rst_n = 1'b1;
        idle_inputs();
        n = 0;
        while (busy_m && n < 40) begin
            n++;
            cycle();
        end
        read_all();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
